// File: rtl/serializer.sv
// serializer: I2S-style left-justified transmitter, SCK in -> BCK/LRCK/SDATA out with valid/ready sample intake
// Ports: SCK master clock; reset_n async active-low; enable frame-boundary run control;
//        left_in/right_in/in_valid/in_ready sample handshake; BCK/LRCK/SDATA serial audio;
//        underrun one-SCK pulse on empty frame start; busy high during frames.
module serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int BCK_HALF = 4
) (
  input  logic                  SCK,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  BCK,
  output logic                  LRCK,
  output logic                  SDATA,
  output logic                  underrun,
  output logic                  busy
);
  localparam int SLOT = 2 * BCK_HALF;
  localparam int FRAME = 2 * DATA_WIDTH * SLOT;
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT);
  localparam logic [CW-1:0] HALF_C = CW'(BCK_HALF);
  localparam logic [CW-1:0] MID_C = CW'(FRAME / 2);
  logic [CW-1:0] cnt, c;
  logic [2*DATA_WIDTH-1:0] sh, sh_n;
  logic [DATA_WIDTH-1:0] left_hold, right_hold;
  logic hold_full, last, start, run, xfer;
  assign in_ready = !hold_full;
  // Outputs are decoded from the next count so they line up with cnt after the edge.
  always_comb begin
    last = cnt == LAST;
    start = last & enable;
    run = !last | enable;
    c = last ? (enable ? '0 : cnt) : cnt + CW'(1);
    xfer = in_valid & in_ready;
    sh_n = start ? (hold_full ? {left_hold, right_hold} : '0)
         : (run && (c % SLOT_C) == '0) ? sh << 1 : sh;
  end
  always_ff @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= LAST;
      sh <= '0;
      hold_full <= 1'b0;
      left_hold <= '0;
      right_hold <= '0;
    end else begin
      cnt <= c;
      sh <= sh_n;
      hold_full <= xfer | (hold_full & !start);
      if (xfer) begin
        left_hold <= left_in;
        right_hold <= right_in;
      end
    end
  end
  always_ff @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      BCK <= 1'b0;
      LRCK <= 1'b0;
      SDATA <= 1'b0;
      underrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      BCK <= run & ((c % SLOT_C) >= HALF_C);
      LRCK <= run & (c < MID_C);
      SDATA <= run & sh_n[2*DATA_WIDTH-1];
      underrun <= start & !hold_full;
      busy <= run;
    end
  end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed self-checking bench for serializer
module tb_serializer;
  logic SCK = 0, reset_n = 0, enable = 0, in_valid = 0;
  logic [23:0] left_in = '0, right_in = '0;
  logic in_ready, BCK, LRCK, SDATA, underrun, busy;
  int checks = 0, errors = 0;
  serializer dut (
    .SCK(SCK), .reset_n(reset_n), .enable(enable), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready), .BCK(BCK), .LRCK(LRCK), .SDATA(SDATA),
    .underrun(underrun), .busy(busy)
  );
  always #5 SCK = ~SCK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [23:0] l, input logic [23:0] r);
    int g = 0;
    logic acc = 0;
    left_in = l;
    right_in = r;
    in_valid = 1;
    while (!acc && g < 2000) begin
      acc = in_ready;
      @(negedge SCK);
      g++;
    end
    in_valid = 0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask
  task automatic find_start(output logic ok);
    int g = 0;
    logic prev = LRCK;
    ok = 0;
    while (g < 2000) begin
      @(negedge SCK);
      g++;
      if (LRCK && !prev) begin
        ok = 1;
        break;
      end
      prev = LRCK;
    end
  endtask
  task automatic frame_check(input string tag, input int drop_at, input logic [47:0] exp_bits,
                             input logic exp_ur, input logic exp_rdy);
    logic [47:0] bits = '0;
    int lr_hi = 0, ur = 0, bz = 0, bad = 0;
    logic ur0 = 0, rdy0 = 0, psd = 0, ok;
    find_start(ok);
    if (!ok) begin
      chk({tag, "_start_timeout"}, 0, 1);
      return;
    end
    for (int i = 0; i < 384; i++) begin
      if (i > 0) @(negedge SCK);
      if (i == drop_at) enable = 0;
      if (i == 0) begin
        ur0 = underrun;
        rdy0 = in_ready;
      end
      if (LRCK) lr_hi++;
      if (underrun) ur++;
      if (busy) bz++;
      if (BCK !== (i % 8 >= 4) || LRCK !== (i < 192) || (i % 8 != 0 && SDATA !== psd)) bad++;
      psd = SDATA;
      if (i % 8 == 4) bits[47 - i / 8] = SDATA;
    end
    chk({tag, "_bits"}, bits, exp_bits);
    chk({tag, "_lrck_high"}, lr_hi, 192);
    chk({tag, "_timing"}, bad, 0);
    chk({tag, "_busy"}, bz, 384);
    chk({tag, "_underrun_cnt"}, ur, exp_ur ? 1 : 0);
    chk({tag, "_underrun_at0"}, ur0, exp_ur);
    chk({tag, "_ready_at0"}, rdy0, exp_rdy);
  endtask
  initial begin
    logic ok;
    int idle;
    #1;
    chk("rst_outs", {BCK, LRCK, SDATA, underrun, busy}, 5'b0);
    repeat (3) @(negedge SCK);
    reset_n = 1;
    @(negedge SCK);
    chk("idle_outs", {BCK, LRCK, SDATA, underrun, busy}, 5'b0);
    chk("idle_ready", in_ready, 1);
    push(24'h800001, 24'h7FFFFE);
    chk("preload_ready", in_ready, 0);
    chk("preload_busy", busy, 0);
    enable = 1;
    frame_check("f1", -1, {24'h800001, 24'h7FFFFE}, 0, 1);
    frame_check("empty", -1, 48'h0, 1, 1);
    fork
      push(24'h5A5A5A, 24'hC3C3C3);
      frame_check("simul", -1, 48'h0, 1, 0);
    join
    fork
      begin
        push(24'h123456, 24'hABCDEF);
        push(24'h654321, 24'hFEDCBA);
        push(24'h000001, 24'hFFFFFF);
        push(24'hF0F0F0, 24'h0F0F0F);
      end
      begin
        frame_check("simul_next", -1, {24'h5A5A5A, 24'hC3C3C3}, 0, 1);
        frame_check("s0", -1, {24'h123456, 24'hABCDEF}, 0, 1);
        frame_check("s1", -1, {24'h654321, 24'hFEDCBA}, 0, 1);
        frame_check("s2", -1, {24'h000001, 24'hFFFFFF}, 0, 1);
        frame_check("s3", -1, {24'hF0F0F0, 24'h0F0F0F}, 0, 1);
      end
    join
    frame_check("drop", 100, 48'h0, 1, 1);
    idle = 0;
    repeat (20) begin
      @(negedge SCK);
      if (BCK || LRCK || SDATA || busy || underrun) idle++;
    end
    chk("drop_idle", idle, 0);
    enable = 1;
    frame_check("reen", -1, 48'h0, 1, 1);
    fork
      push(24'hFFFFFF, 24'hFFFFFF);
      begin
        find_start(ok);
        chk("rst_find", ok, 1);
        repeat (250) @(negedge SCK);
      end
    join
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_ready", in_ready, 0);
    reset_n = 0;
    #1;
    chk("mid_rst_outs", {BCK, LRCK, SDATA, underrun, busy}, 5'b0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge SCK);
    @(negedge SCK);
    reset_n = 1;
    frame_check("post_rst", -1, 48'h0, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
